// File: rtl/rockcessor_pkg.sv
// Shared definitions for the register-file bitmap path: bank geometry,
// memory word geometry and the bitmap loader state encoding.
package rockcessor_pkg;

    localparam int unsigned BM_WIDTH   = 1500;
    localparam int unsigned BM_BANKS   = 3;
    localparam int unsigned MEM_W      = 16;
    localparam int unsigned MEM_ADDR_W = 16;

    typedef logic [1:0]          bm_sel_t;
    typedef logic [BM_WIDTH-1:0] bm_t;

    typedef enum logic [1:0] {
        LDR_IDLE,
        LDR_REQ,
        LDR_GAP,
        LDR_COMMIT
    } ldr_state_t;

    // Number of memory words needed to cover a bitmap of 'bits' bits.
    function automatic int unsigned words_per_bitmap(input int unsigned bits,
                                                     input int unsigned word_w);
        return (bits + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/bitmap_loader_if.sv
// Bus bundle of the bitmap loader: control (start/busy/done), memory read
// port (req/valid handshake) and the register-file bitmap write port.
interface bitmap_loader_if
    import rockcessor_pkg::*;
#(
    parameter int unsigned B      = BM_WIDTH,
    parameter int unsigned W      = MEM_W,
    parameter int unsigned ADDR_W = MEM_ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    bm_sel_t           dest;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_rdata;
    logic              mem_valid;
    logic              wbm;
    bm_sel_t           wbm_addr;
    logic [B-1:0]      wbm_data;

    // Loader side
    modport master (
        input  start, base_addr, dest, mem_rdata, mem_valid,
        output busy, done, mem_rd, mem_addr, wbm, wbm_addr, wbm_data
    );

    // Control unit / memory / register-file side
    modport slave (
        output start, base_addr, dest, mem_rdata, mem_valid,
        input  busy, done, mem_rd, mem_addr, wbm, wbm_addr, wbm_data
    );
endinterface

// File: rtl/bm_word_packer.sv
// Word-assembly buffer for the bitmap loader. Words arrive in order 0..NW-1
// and are shifted in from the top, so after NW loads word 0 sits in the LSBs
// and word k occupies bits [k*W +: W]. Bits at index >= B are dropped.
module bm_word_packer
    import rockcessor_pkg::*;
#(
    parameter int unsigned B  = BM_WIDTH,
    parameter int unsigned W  = MEM_W,
    parameter int unsigned NW = words_per_bitmap(BM_WIDTH, MEM_W)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] word,
    output logic [B-1:0] bits
);

    logic [NW*W-1:0] shreg_q;

    // Shift register: clear on a new load, shift one word in per accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (clear) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= {word, shreg_q[NW*W-1:W]};
        end
    end

    assign bits = shreg_q[B-1:0];

endmodule

// File: rtl/bitmap_loader.sv
// Bitmap loader: on start, reads NW consecutive memory words from base_addr
// with a req/valid handshake, assembles them and commits the B-bit bitmap to
// register dest with a single-cycle wbm/done pulse.
// Optional feature: define BITMAP_LOADER_ABORT_EN to add the 'abort' input.
module bitmap_loader
    import rockcessor_pkg::*;
#(
    parameter int unsigned B      = BM_WIDTH,
    parameter int unsigned W      = MEM_W,
    parameter int unsigned ADDR_W = MEM_ADDR_W
)(
    input  logic            clk,
    input  logic            rst,
`ifdef BITMAP_LOADER_ABORT_EN
    input  logic            abort,
`endif
    bitmap_loader_if.master bus
);

    localparam int unsigned NW = words_per_bitmap(B, W);
    localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [KW-1:0]     k_q;
    bm_sel_t           dest_q;
    logic [B-1:0]      held_q;
    logic [B-1:0]      packed_bits;

    logic accept;
    logic take_word;
    logic last_word;
    logic abort_hit;

`ifdef BITMAP_LOADER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_word = (k_q == KW'(NW - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake events
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        take_word = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (bus.start && (bus.dest != 2'b11)) begin
                    accept  = 1'b1;
                    state_d = LDR_REQ;
                end
            end
            LDR_REQ: begin
                if (abort_hit) begin
                    state_d = LDR_IDLE;
                end else if (bus.mem_valid) begin
                    take_word = 1'b1;
                    state_d   = last_word ? LDR_COMMIT : LDR_GAP;
                end
            end
            LDR_GAP: begin
                state_d = abort_hit ? LDR_IDLE : LDR_REQ;
            end
            LDR_COMMIT: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    // Address/word counters, captured destination and post-commit bitmap hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            k_q    <= '0;
            dest_q <= '0;
            held_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.base_addr;
                k_q    <= '0;
                dest_q <= bus.dest;
            end else if (take_word && !last_word) begin
                // The last word leaves the address on the final request
                addr_q <= addr_q + ADDR_W'(1);
                k_q    <= k_q + KW'(1);
            end
            if (state_q == LDR_COMMIT) begin
                held_q <= packed_bits;
            end
        end
    end

    bm_word_packer #(
        .B  (B),
        .W  (W),
        .NW (NW)
    ) u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .load  (take_word),
        .word  (bus.mem_rdata),
        .bits  (packed_bits)
    );

    assign bus.busy     = (state_q != LDR_IDLE);
    assign bus.mem_rd   = (state_q == LDR_REQ);
    assign bus.mem_addr = addr_q;
    assign bus.wbm      = (state_q == LDR_COMMIT);
    assign bus.done     = (state_q == LDR_COMMIT);
    assign bus.wbm_addr = dest_q;
    // The packer is live during the commit cycle; afterwards the held copy
    // keeps wbm_data stable while the next load reuses the packer.
    assign bus.wbm_data = (state_q == LDR_COMMIT) ? packed_bits : held_q;

endmodule

// File: tb/tb_bitmap_loader.sv
// Testbench for bitmap_loader: table-driven loads against a behavioural
// memory, plus sequences for ignored starts, mid-load reset and abort.
module tb_bitmap_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef BITMAP_LOADER_ABORT_EN
    logic abort = 1'b0;
`endif

    always #5 clk = ~clk;

    bitmap_loader_if #(.B(1500), .W(16), .ADDR_W(16)) bus ();

    bitmap_loader #(.B(1500), .W(16), .ADDR_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef BITMAP_LOADER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] base;
        logic [1:0]  dest;
        int          mode;          // 0: word=k, 1: 0xFFFF, 2: addr^0xA5C3
        int          lat_lo;
        int          lat_hi;
        int          mid_start;
        logic [15:0] exp_last_addr;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
        logic [11:0] exp_top;
        int          exp_cycles;    // 0: not checked
        int          exp_wrap;
    } vec_t;

    vec_t vecs[4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] tb_base  = '0;
    int          mem_mode = 0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    bit          mem_en   = 1'b1;

    int          wbm_cnt, req_cnt, gap_bad, seq_bad, dw_bad, busy_cnt, low_run;
    int          wbm_cyc, s_cyc;
    bit          wrap_seen;
    bit          prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [1:0]  cap_addr;
    logic [1499:0] cap_data;

    function automatic logic [15:0] word_for(input logic [15:0] addr,
                                             input logic [15:0] base, input int m);
        case (m)
            0:       return addr - base;
            1:       return 16'hFFFF;
            default: return addr ^ 16'hA5C3;
        endcase
    endfunction

    function automatic logic [1499:0] model_bitmap(input logic [15:0] base, input int m);
        logic [94*16-1:0] acc;
        acc = '0;
        for (int k = 0; k < 94; k++) acc[k*16 +: 16] = word_for(base + 16'(k), base, m);
        return acc[1499:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wbm_cnt = 0; req_cnt = 0; gap_bad = 0; seq_bad = 0; dw_bad = 0;
        busy_cnt = 0; low_run = 0; wrap_seen = 1'b0; wbm_cyc = 0;
    endtask

    always @(posedge clk) cyc++;

    // Memory model: answers a held request after 'lat' cycles (lat >= 1)
    initial begin : mem_model
        int unsigned age;
        int unsigned lat;
        age = 0; lat = 1;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_en) begin
                bus.mem_valid = 1'b0;
                if (bus.mem_rd) begin
                    age++;
                    if (age == 1) lat = $urandom_range(lat_hi, lat_lo);
                    if (age == 1 + lat) begin
                        bus.mem_valid = 1'b1;
                        bus.mem_rdata = word_for(bus.mem_addr, tb_base, mem_mode);
                    end
                end else begin
                    age = 0;
                end
            end
        end
    end

    // Bus monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done !== bus.wbm) dw_bad++;
        if (bus.wbm) begin
            wbm_cnt++;
            wbm_cyc  = cyc;
            cap_addr = bus.wbm_addr;
            cap_data = bus.wbm_data;
        end
        if (bus.mem_rd) begin
            if (!prev_rd) begin
                if (req_cnt != 0 && low_run != 1) gap_bad++;
                if (bus.mem_addr !== tb_base + 16'(req_cnt)) seq_bad++;
                if (req_cnt != 0 && prev_addr == 16'hFFFF && bus.mem_addr == 16'h0000)
                    wrap_seen = 1'b1;
                req_cnt++;
            end else if (bus.mem_addr !== prev_addr) begin
                seq_bad++;
            end
            low_run   = 0;
            prev_addr = bus.mem_addr;
        end else if (bus.busy) begin
            low_run++;
        end
        prev_rd = bus.mem_rd;
    end

    task automatic wait_wbm(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (wbm_cnt > 0) got = 1'b1;
        end
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        bit got;
        logic [1499:0] exp_full;
        string p;
        p = $sformatf("v%0d_", idx);
        exp_full = model_bitmap(v.base, v.mode);
        tb_base = v.base; mem_mode = v.mode; lat_lo = v.lat_lo; lat_hi = v.lat_hi;
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr = v.base; bus.dest = v.dest; bus.start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.base_addr = 16'h0BAD; bus.dest = 2'd0;
        if (v.mid_start != 0) begin
            repeat (30) @(posedge clk);
            #1 bus.start = 1'b1; bus.base_addr = 16'h3000; bus.dest = 2'd0;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        wait_wbm(got);
        chk({p, "wbm_seen"}, 64'(got), 64'd1);
        repeat (5) @(negedge clk);
        chk({p, "wbm_count"}, 64'(wbm_cnt), 64'd1);
        chk({p, "wbm_addr"}, 64'(cap_addr), 64'(v.dest));
        chk({p, "data_w0"}, 64'(cap_data[15:0]), 64'(v.exp_w0));
        chk({p, "data_w1"}, 64'(cap_data[31:16]), 64'(v.exp_w1));
        chk({p, "data_top"}, 64'(cap_data[1499:1488]), 64'(v.exp_top));
        chk({p, "data_full"}, 64'(cap_data === exp_full), 64'd1);
        chk({p, "data_hold"}, 64'(bus.wbm_data === exp_full), 64'd1);
        chk({p, "last_addr"}, 64'(bus.mem_addr), 64'(v.exp_last_addr));
        chk({p, "req_count"}, 64'(req_cnt), 64'd94);
        chk({p, "gap_one_cycle"}, 64'(gap_bad), 64'd0);
        chk({p, "addr_sequence"}, 64'(seq_bad), 64'd0);
        chk({p, "done_eq_wbm"}, 64'(dw_bad), 64'd0);
        chk({p, "busy_after"}, 64'(bus.busy), 64'd0);
        if (v.exp_cycles != 0) chk({p, "latency"}, 64'(wbm_cyc - s_cyc), 64'(v.exp_cycles));
        if (v.exp_wrap != 0) chk({p, "addr_wrap"}, 64'(wrap_seen), 64'd1);
    endtask

    initial begin : main
        bit got;
        vecs[0] = '{16'h1000, 2'd1, 0, 1, 1, 0, 16'h105D, 16'h0000, 16'h0001, 12'h05D, 282, 0};
        vecs[1] = '{16'h2000, 2'd2, 1, 1, 6, 1, 16'h205D, 16'hFFFF, 16'hFFFF, 12'hFFF, 0,   0};
        vecs[2] = '{16'hFFD0, 2'd0, 0, 1, 1, 0, 16'h002D, 16'h0000, 16'h0001, 12'h05D, 282, 1};
        vecs[3] = '{16'h0040, 2'd1, 2, 2, 2, 0, 16'h009D, 16'hA583, 16'hA582, 12'h55E, 376, 0};

        bus.start = 1'b0; bus.base_addr = '0; bus.dest = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        chk("rst_wbm", 64'(bus.wbm), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wbm_addr", 64'(bus.wbm_addr), 64'd0);
        chk("rst_wbm_data_zero", 64'(bus.wbm_data == '0), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) do_vec(vecs[i], i);

        // start with dest=3 is ignored
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr = 16'h4000; bus.dest = 2'd3; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("dest3_busy_cycles", 64'(busy_cnt), 64'd0);
        chk("dest3_requests", 64'(req_cnt), 64'd0);
        chk("dest3_wbm", 64'(wbm_cnt), 64'd0);

        // reset asserted at word 40
        tb_base = 16'h0800; mem_mode = 0; lat_lo = 1; lat_hi = 1;
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr = 16'h0800; bus.dest = 2'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (req_cnt >= 41) got = 1'b1;
        end
        chk("rst40_reached", 64'(got), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst40_busy", 64'(bus.busy), 64'd0);
        chk("rst40_mem_rd", 64'(bus.mem_rd), 64'd0);
        chk("rst40_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst40_wbm_data_zero", 64'(bus.wbm_data == '0), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst40_no_wbm", 64'(wbm_cnt), 64'd0);
        do_vec(vecs[0], 4);

`ifdef BITMAP_LOADER_ABORT_EN
        // abort at word 10, then a stale mem_valid
        tb_base = 16'h0500; mem_mode = 0; lat_lo = 1; lat_hi = 1;
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr = 16'h0500; bus.dest = 2'd0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (req_cnt >= 11) got = 1'b1;
        end
        chk("abort_reached", 64'(got), 64'd1);
        mem_en = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = 16'h1234;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_mem_rd", 64'(bus.mem_rd), 64'd0);
        @(posedge clk); #1 bus.mem_valid = 1'b0;
        mem_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_wbm", 64'(wbm_cnt), 64'd0);
        chk("abort_idle_after_stale", 64'(bus.busy), 64'd0);
        do_vec(vecs[3], 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
